bcd_convert_seq: RTL



---
 rtl/bcd_convert_seq.sv | 83 ++++++++
 1 files changed

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential double-dabble binary-to-BCD converter.
// One correction/shift stage is reused for WIDTH clocks per conversion.
module bcd_convert_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      x,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_fix;
  logic [SW-1:0]   sr_next;
  logic [CW-1:0]   cnt;

  // Add 3 to every BCD digit >= 5, then shift the whole register left by one.
  always_comb begin
    sr_fix = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[WIDTH+4*k +: 4] >= 4'd5)
        sr_fix[WIDTH+4*k +: 4] = sr[WIDTH+4*k +: 4] + 4'd3;
    end
    sr_next = {sr_fix[SW-2:0], 1'b0};
  end

  // Control FSM with registered busy/done; the result register only loads on the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {{(4*DIGITS){1'b0}}, x};
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= sr_next[SW-1:WIDTH];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
